trng_seed_ctrl: RTL and testbench

- Sequences the free-running ring-oscillator TRNG and delivers vetted seed material to the AES-CTR DRBG.
- On request: one-time post-reset warm-up discard, then samples the 64-bit TRN shift register once per 64 cycles (fully refreshed word each time).
- Each word passes online health tests; accepted words are packed into a SEED_WORDS×64-bit seed and handed over with a valid/ready handshake.
- Repeated health failures raise a sticky error.

---
 rtl/trng_seed_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_trng_seed_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_seed_ctrl.sv
// trng_seed_ctrl: sequences the free-running ring-oscillator TRNG and hands
// vetted seed material to the AES-CTR DRBG.
//
// Flow: IDLE -> (WARMUP, once after reset) -> COLLECT -> DONE -> IDLE.
// In COLLECT the 64-bit TRN shift register is sampled once every 64 cycles,
// so every sample is a fully refreshed word. Each sample runs through the
// online health tests (stuck-at-0, stuck-at-1, repeat of the previous
// sample). Accepted words are shifted into the seed, first word ending up in
// the MSBs. MAX_FAIL consecutive rejects park the block in ERROR until
// err_clr.
//
// Handshake: seed_valid rises when a complete seed is held and stays high,
// with seed stable, until the cycle in which seed_ready is also high; that
// edge transfers the seed, clears it and returns to IDLE. seed_ready is a
// don't-care while seed_valid is low, and seed_req is only looked at in IDLE.
//
// The seed output is gated to zero outside DONE so a partially assembled
// seed never appears on the port.

module trng_seed_ctrl #(
  parameter int SEED_WORDS = 6,
  parameter int WARMUP_CYC = 256,
  parameter int MAX_FAIL   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [63:0]                trn_in,
  input  logic                       seed_req,
  output logic [SEED_WORDS*64-1:0]   seed,
  output logic                       seed_valid,
  input  logic                       seed_ready,
  output logic                       busy,
  output logic                       err,
  input  logic                       err_clr
);

  localparam int SEED_W = SEED_WORDS * 64;
  localparam int WARM_W = $clog2(WARMUP_CYC + 1);

  // Counter compare constants, sized to the counters they are compared with.
  localparam logic [4:0]        WORDS_FULL = 5'(SEED_WORDS);
  localparam logic [4:0]        FAIL_LIM   = 5'(MAX_FAIL);
  localparam logic [WARM_W-1:0] WARM_LAST  = WARM_W'(WARMUP_CYC - 1);
  localparam logic [WARM_W-1:0] WARM_MAX   = WARM_W'(WARMUP_CYC);
  localparam logic [5:0]        BIT_LAST   = 6'd63;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_COLLECT = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  // Sequencing state.
  logic              warmed;     // warm-up already done since reset
  logic [WARM_W-1:0] warm_cnt;   // cycles spent in WARMUP, saturating
  logic [5:0]        bit_cnt;    // position inside the 64-cycle refresh window
  logic [4:0]        word_cnt;   // accepted words in the current seed
  logic [4:0]        fail_cnt;   // consecutive rejected samples

  // Health-test history.
  logic [63:0]       last_word;  // previous sample, accepted or rejected
  logic              have_last;  // last_word holds a real sample

  // Seed assembly.
  logic [SEED_W-1:0] seed_q;
  logic [SEED_W-1:0] seed_shift;

  // Sample strobe and health test results.
  logic sample;
  logic hit_zero;
  logic hit_ones;
  logic hit_repeat;
  logic word_ok;
  logic accept;
  logic reject;
  logic warm_done;
  logic handoff;

  // ---------------------------------------------------------------------
  // Combinational datapath helpers
  // ---------------------------------------------------------------------

  // The TRN register has been completely refilled on the last cycle of each
  // 64-cycle window; that is the only cycle a word is taken.
  assign sample     = (state == S_COLLECT) && (bit_cnt == BIT_LAST);

  assign hit_zero   = (trn_in == 64'h0);
  assign hit_ones   = (trn_in == 64'hFFFF_FFFF_FFFF_FFFF);
  // The very first sample after reset has no predecessor to compare with.
  assign hit_repeat = have_last && (trn_in == last_word);
  assign word_ok    = !(hit_zero || hit_ones || hit_repeat);

  assign accept     = sample && word_ok;
  assign reject     = sample && !word_ok;

  assign warm_done  = (state == S_WARMUP) && (warm_cnt == WARM_LAST);
  assign handoff    = (state == S_DONE) && seed_ready;

  // Shift a new word in at the LSB end so the first accepted word drifts up
  // to the MSBs once the seed is full.
  generate
    if (SEED_WORDS == 1) begin : g_seed_one
      assign seed_shift = trn_in;
    end else begin : g_seed_many
      assign seed_shift = {seed_q[SEED_W-65:0], trn_in};
    end
  endgenerate

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; counters are registered, so DONE/ERROR are entered on
  // the edge after the sample that filled the seed or hit the fail limit.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (seed_req) begin
          state_nxt = warmed ? S_COLLECT : S_WARMUP;
        end
      end
      S_WARMUP: begin
        if (warm_done) begin
          state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (word_cnt == WORDS_FULL) begin
          state_nxt = S_DONE;
        end else if (fail_cnt == FAIL_LIM) begin
          state_nxt = S_ERROR;
        end
      end
      S_DONE: begin
        if (seed_ready) begin
          state_nxt = S_IDLE;
        end
      end
      S_ERROR: begin
        if (err_clr) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the state alone.
  always_comb begin
    seed_valid = 1'b0;
    busy       = 1'b0;
    err        = 1'b0;
    seed       = '0;
    unique case (state)
      S_WARMUP,
      S_COLLECT: begin
        busy = 1'b1;
      end
      S_DONE: begin
        seed_valid = 1'b1;
        seed       = seed_q;
      end
      S_ERROR: begin
        err = 1'b1;
      end
      default: begin
        seed_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Counters and datapath registers
  // ---------------------------------------------------------------------

  // Warm-up counter: cleared outside WARMUP, saturates at WARMUP_CYC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt <= '0;
    end else if (state == S_WARMUP) begin
      if (warm_cnt != WARM_MAX) begin
        warm_cnt <= warm_cnt + 1'b1;
      end
    end else begin
      warm_cnt <= '0;
    end
  end

  // Warm-up happens once per reset; later requests go straight to COLLECT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warmed <= 1'b0;
    end else if (warm_done) begin
      warmed <= 1'b1;
    end
  end

  // Bit counter: zero on entry to COLLECT, free-running (63 -> 0) inside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (state == S_COLLECT) begin
      bit_cnt <= bit_cnt + 1'b1;
    end else begin
      bit_cnt <= '0;
    end
  end

  // Seed register and accepted-word count; cleared on hand-off and in ERROR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_q   <= '0;
      word_cnt <= '0;
    end else if (accept) begin
      seed_q   <= seed_shift;
      word_cnt <= word_cnt + 1'b1;
    end else if (handoff || (state == S_ERROR)) begin
      seed_q   <= '0;
      word_cnt <= '0;
    end
  end

  // Consecutive-reject counter: any accept restarts it, err_clr leaves ERROR
  // with a clean count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_cnt <= '0;
    end else if (accept) begin
      fail_cnt <= '0;
    end else if (reject) begin
      fail_cnt <= fail_cnt + 1'b1;
    end else if ((state == S_ERROR) && err_clr) begin
      fail_cnt <= '0;
    end
  end

  // Repeat-test history follows every sample, accepted or not, across seeds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_word <= '0;
      have_last <= 1'b0;
    end else if (sample) begin
      last_word <= trn_in;
      have_last <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trng_seed_ctrl.sv
// Testbench for trng_seed_ctrl (SEED_WORDS=2, WARMUP_CYC=8, MAX_FAIL=4).
// The driver feeds chosen words only on the cycles the controller should
// sample and random filler everywhere else. A reference model applies the
// health rules to the chosen words and pushes {expected edge, expected seed}
// into exp_q; a monitor pops and compares when seed_valid rises.

module tb_trng_seed_ctrl;

  localparam int SW     = 2;
  localparam int WC     = 8;
  localparam int MF     = 4;
  localparam int SEED_W = SW * 64;
  localparam int EXP_W  = SEED_W + 32;

  localparam logic [63:0] WORD_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] WORD_B = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [63:0]       trn_in;
  logic              seed_req;
  logic [SEED_W-1:0] seed;
  logic              seed_valid;
  logic              seed_ready;
  logic              busy;
  logic              err;
  logic              err_clr;

  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  trng_seed_ctrl #(
    .SEED_WORDS (SW),
    .WARMUP_CYC (WC),
    .MAX_FAIL   (MF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trn_in     (trn_in),
    .seed_req   (seed_req),
    .seed       (seed),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .busy       (busy),
    .err        (err),
    .err_clr    (err_clr)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [63:0]      stim_q[$];

  // Reference model of the controller's observable history.
  bit          m_warmed    = 1'b0;
  bit          m_have_last = 1'b0;
  logic [63:0] m_last      = '0;
  int          m_fail      = 0;

  bit hold_req = 1'b0;
  bit rand_clr = 1'b0;

  task automatic check(input string name, input logic [SEED_W-1:0] act,
                       input logic [SEED_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  function automatic bit healthy(input logic [63:0] w);
    if (w == 64'h0 || w == ONES) return 1'b0;
    if (m_have_last && w == m_last) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [SEED_W-1:0] pack(input logic [63:0] ws[$]);
    logic [SEED_W-1:0] r;
    r = '0;
    for (int i = 0; i < SW; i++) r[(SW-1-i)*64 +: 64] = ws[i];
    return r;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [EXP_W-1:0]  e;
    logic [SEED_W-1:0] mon_seed;
    bit                mon_active;
    mon_active = 1'b0;
    mon_seed   = '0;
    forever begin
      @(negedge clk);
      if (seed_valid && !mon_active) begin
        if (exp_q.size() == 0) begin
          check("seed_valid_unexpected", seed_valid, 0);
        end else begin
          e        = exp_q.pop_front();
          mon_seed = e[SEED_W-1:0];
          check("seed_value", seed, mon_seed);
          check("valid_latency_edge", cyc, e[EXP_W-1:SEED_W]);
        end
        mon_active = 1'b1;
      end else if (seed_valid && mon_active) begin
        check("seed_stable", seed, mon_seed);
      end
      if (seed_valid) check("busy_in_done", busy, 0);
      if (!seed_valid) mon_active = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end at #1 after a rising edge.

  // Issue a request; returns the edge number at which it was taken.
  task automatic do_request(output int t);
    seed_req = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    if (!hold_req) seed_req = 1'b0;
  endtask

  // Run one request. outcome: 0 seed expected, 1 error expected,
  // 2 stopped after max_smp samples.
  task automatic run_seed(input int max_smp, output int outcome);
    int t, off, e, nsmp;
    bit smp;
    logic [63:0] w;
    logic [63:0] acc[$];
    off     = m_warmed ? 0 : WC;
    nsmp    = 0;
    outcome = -1;
    do_request(t);
    check("busy_after_req", busy, 1);
    m_warmed = 1'b1;
    for (int g = 0; g < 4000 && outcome < 0; g++) begin
      e   = cyc;
      smp = (e + 1 > t + off) && (((e + 1 - t - off) % 64) == 0);
      if (smp) w = (stim_q.size() > 0) ? stim_q.pop_front() : rand_word();
      else     w = rand_word();
      trn_in  = w;
      err_clr = rand_clr && ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
      if (smp) begin
        nsmp++;
        if (healthy(w)) begin
          acc.push_back(w);
          m_fail = 0;
        end else begin
          m_fail++;
        end
        m_last      = w;
        m_have_last = 1'b1;
        if (acc.size() == SW) begin
          exp_q.push_back({32'(cyc + 1), pack(acc)});
          outcome = 0;
        end else if (m_fail == MF) begin
          outcome = 1;
        end else if (nsmp == max_smp) begin
          outcome = 2;
        end
      end
    end
    err_clr = 1'b0;
    stim_q.delete();
    if (outcome < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_seed_budget: no model outcome within cycle budget");
      outcome = 2;
    end
  endtask

  // Let DONE be entered, stall hold cycles, then accept the seed.
  task automatic finish_seed(input int hold);
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    seed_ready = 1'b1;
    @(posedge clk); #1;
    seed_ready = 1'b0;
    seed_req   = 1'b0;
    check("seed_cleared", seed, 0);
    check("valid_cleared", seed_valid, 0);
    repeat (3) begin
      check("idle_after_handoff", busy, 0);
      @(posedge clk); #1;
    end
    check("no_second_seed", seed_valid, 0);
  endtask

  task automatic handle_error();
    check("err_not_yet", err, 0);
    @(posedge clk); #1;
    check("err_set", err, 1);
    check("err_busy", busy, 0);
    check("err_valid", seed_valid, 0);
    check("err_seed", seed, 0);
    seed_req = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("err_req_ignored", err, 1);
      check("err_req_no_busy", busy, 0);
    end
    seed_req = 1'b0;
    err_clr  = 1'b1;
    @(posedge clk); #1;
    err_clr  = 1'b0;
    check("err_cleared", err, 0);
    check("idle_after_clr", busy, 0);
    m_fail = 0;
  endtask

  task automatic full_seed(input int hold);
    int oc;
    run_seed(100, oc);
    if (oc == 0) finish_seed(hold);
    else if (oc == 1) handle_error();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int oc;
    rst        = 1'b1;
    trn_in     = '0;
    seed_req   = 1'b0;
    seed_ready = 1'b0;
    err_clr    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_seed", seed, 0);
    check("rst_valid", seed_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold request with A then B, consumer stalls 10 cycles.
    stim_q = '{WORD_A, WORD_B};
    full_seed(10);

    // Warm request with random words.
    full_seed(2);

    // Health rejects: zero, then a repeat, with accepts in between.
    stim_q = '{64'h0, WORD_A, WORD_A, WORD_B};
    full_seed(0);

    // Escalation: four all-ones samples in a row.
    stim_q = '{ONES, ONES, ONES, ONES};
    run_seed(100, oc);
    if (oc == 1) handle_error();
    else check("escalation_outcome", seed_valid, 0);

    // Warm request after err_clr.
    full_seed(1);

    // Asynchronous reset mid-COLLECT after one accepted word.
    run_seed(1, oc);
    repeat (5) begin @(posedge clk); #1; end
    check("busy_pre_reset", busy, 1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_seed", seed, 0);
    check("async_rst_valid", seed_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_err", err, 0);
    m_warmed    = 1'b0;
    m_have_last = 1'b0;
    m_last      = '0;
    m_fail      = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold again, request held high through COLLECT and DONE.
    hold_req = 1'b1;
    full_seed(4);
    hold_req = 1'b0;

    // Randomized runs with injected bad words and stray err_clr pulses.
    rand_clr = 1'b1;
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < SW + 2; k++) begin
        int r;
        logic [63:0] w;
        r = $urandom_range(0, 9);
        if (r == 0)                w = 64'h0;
        else if (r == 1)           w = ONES;
        else if (r == 2 && k > 0)  w = stim_q[k-1];
        else                       w = rand_word();
        stim_q.push_back(w);
      end
      hold_req = ($urandom_range(0, 1) == 1);
      full_seed($urandom_range(0, 5));
      hold_req = 1'b0;
    end
    rand_clr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
